// File: rtl/cvp_pkg.sv
// Shared CVP14 vector datapath definitions: opcodes, sequencer states, default geometry.
package cvp_pkg;

  // Vector memory opcodes
  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;

  // Default vector geometry
  localparam int unsigned DEF_LANES  = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vector_lane_buffer.sv
// LANES x DATA_W register array: whole-vector load, single-lane write, lane-indexed read.
module vector_lane_buffer
  import cvp_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load_all,
  input  logic [LANES*DATA_W-1:0] i_all_data,
  input  logic                    i_we,
  input  logic [LANE_W-1:0]       i_wlane,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic [LANE_W-1:0]       i_rlane,
  output logic [DATA_W-1:0]       o_rdata,
  output logic [LANES*DATA_W-1:0] o_all
);

  logic [DATA_W-1:0] r_lane [LANES];

  // Lane storage; a whole-vector load takes precedence over a single-lane write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_lane[i] <= '0;
      end
    end else if (i_load_all) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_lane[i] <= i_all_data[i*DATA_W +: DATA_W];
      end
    end else if (i_we) begin
      r_lane[i_wlane] <= i_wdata;
    end
  end

  assign o_rdata = r_lane[i_rlane];

  for (genvar g = 0; g < int'(LANES); g++) begin : g_pack
    assign o_all[g*DATA_W +: DATA_W] = r_lane[g];
  end

endmodule

// File: rtl/vector_mem_sequencer.sv
// VLD/VST sequencer: moves one vector register across the memory bus one lane per beat.
module vector_mem_sequencer
  import cvp_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_op_store,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic [ADDR_W-1:0]       i_stride,
  input  logic [LANES*DATA_W-1:0] i_st_data,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_ld_we,
  output logic [LANES*DATA_W-1:0] o_ld_data,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic                    o_mem_rd,
  output logic                    o_mem_wr,
  output logic [DATA_W-1:0]       o_mem_wdata,
  input  logic [DATA_W-1:0]       i_mem_rdata,
  input  logic                    i_mem_ready
);

  seq_state_t        r_state;
  logic              r_op;
  logic              r_busy;
  logic              r_done;
  logic              r_ld_we;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [LANE_W-1:0] r_lane;

  logic w_st_load;
  logic w_ld_beat;
  logic w_last;

  // Each buffer leaves one view unused: loads only need the full vector, stores only one lane
  logic [DATA_W-1:0]       w_unused_ld_lane;
  logic [LANES*DATA_W-1:0] w_unused_st_all;

  assign w_st_load = (r_state == IDLE) && i_start && i_op_store;
  // Abort wins over a beat completing in the same cycle
  assign w_ld_beat = (r_state == XFER) && !i_abort && i_mem_ready && !r_op;
  assign w_last    = (r_lane == LANE_W'(LANES - 1));

  vector_lane_buffer #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_st_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load_all (w_st_load),
    .i_all_data (i_st_data),
    .i_we       (1'b0),
    .i_wlane    (r_lane),
    .i_wdata    ({DATA_W{1'b0}}),
    .i_rlane    (r_lane),
    .o_rdata    (o_mem_wdata),
    .o_all      (w_unused_st_all)
  );

  vector_lane_buffer #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_ld_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load_all (1'b0),
    .i_all_data ({(LANES*DATA_W){1'b0}}),
    .i_we       (w_ld_beat),
    .i_wlane    (r_lane),
    .i_wdata    (i_mem_rdata),
    .i_rlane    (r_lane),
    .o_rdata    (w_unused_ld_lane),
    .o_all      (o_ld_data)
  );

  // Sequencer FSM with registered request/status outputs, lane counter and address adder
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_op     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ld_we  <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_addr   <= '0;
      r_stride <= '0;
      r_lane   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state  <= XFER;
            r_op     <= i_op_store;
            r_stride <= i_stride;
            r_addr   <= i_base_addr;
            r_lane   <= '0;
            r_busy   <= 1'b1;
            r_mem_rd <= !i_op_store;
            r_mem_wr <= i_op_store;
          end
        end
        XFER: begin
          if (i_abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
          end else if (i_mem_ready) begin
            if (w_last) begin
              r_state  <= DONE;
              r_mem_rd <= 1'b0;
              r_mem_wr <= 1'b0;
              r_done   <= 1'b1;
              r_ld_we  <= !r_op;
            end else begin
              r_lane <= r_lane + LANE_W'(1);
              // Wraps modulo 2^ADDR_W by truncation
              r_addr <= r_addr + r_stride;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ld_we <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_ld_we    = r_ld_we;
  assign o_mem_rd   = r_mem_rd;
  assign o_mem_wr   = r_mem_wr;
  assign o_mem_addr = r_addr;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: memory model, beat scoreboard, cycle checks.
module tb_vector_mem_sequencer;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned VW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              op_store = 1'b0;
  logic              abort = 1'b0;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [VW-1:0]     st_data = '0;

  logic              busy, done, ld_we, mem_rd, mem_wr;
  logic [VW-1:0]     ld_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // Memory: unwritten word a reads back as a
  bit [DATA_W-1:0] mem     [65536];
  bit              written [65536];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [VW-1:0] exp_ld = '0;

  vector_mem_sequencer #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_op_store  (op_store),
    .i_base_addr (base_addr),
    .i_stride    (stride),
    .i_st_data   (st_data),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
    .o_ld_we     (ld_we),
    .o_ld_data   (ld_data),
    .o_mem_addr  (mem_addr),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = written[mem_addr] ? mem[mem_addr] : mem_addr;

  // Memory write port
  always @(posedge clk) begin
    if (rst_n && mem_wr && mem_ready) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic [33:0] prev_req = '0;

  // Beat monitor: pops the scoreboard on each completed beat and checks stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check_eq("hold", {mem_rd, mem_wr, mem_addr, mem_wdata}, prev_req);
      end
      if ((mem_rd || mem_wr) && mem_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_unexpected", {mem_rd, mem_wr}, 2'b00);
        end else begin
          check_eq("beat", {16'(cyc), mem_addr, mem_wr, mem_wr ? mem_wdata : 16'h0},
                   {16'(exp_q[0].cyc), exp_q[0].addr, exp_q[0].wr, exp_q[0].data});
          exp_q.pop_front();
        end
      end
      prev_stall <= (mem_rd || mem_wr) && !mem_ready && !abort;
      prev_req   <= {mem_rd, mem_wr, mem_addr, mem_wdata};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // One operation: start on cycle 0, then run to done (or to the abort cycle)
  task automatic run_op(input string tag, input bit op, input logic [ADDR_W-1:0] base,
                        input logic [ADDR_W-1:0] strd, input logic [VW-1:0] sdata,
                        input bit stall, input int abort_cyc, input bit poke_start);
    int                exp_done, n_beats, done_cyc, n_we, last;
    logic [ADDR_W-1:0] a;
    logic [VW-1:0]     new_ld;
    exp_done = stall ? 2 * LANES + 1 : LANES + 1;
    n_beats  = LANES;
    if (abort_cyc >= 0) n_beats = stall ? (abort_cyc - 1) / 2 : abort_cyc - 1;
    new_ld = exp_ld;
    a      = base;
    for (int j = 0; j < n_beats; j++) begin
      exp_q.push_back('{stall ? 2 * (j + 1) : j + 1, a, op,
                        op ? sdata[j*DATA_W +: DATA_W] : 16'h0});
      if (!op) new_ld[j*DATA_W +: DATA_W] = a;
      a = a + strd;
    end

    @(posedge clk); #1;
    cyc       = 0;
    start     = 1'b1;
    op_store  = op;
    base_addr = base;
    stride    = strd;
    st_data   = sdata;
    abort     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq($sformatf("%s_idle", tag), {busy, done, ld_we, mem_rd, mem_wr}, 5'b0);
    check_eq($sformatf("%s_ld_hold", tag), ld_data, exp_ld);
    exp_ld = new_ld;

    last     = (abort_cyc >= 0) ? abort_cyc : exp_done;
    done_cyc = -1;
    n_we     = 0;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      cyc       = c;
      start     = poke_start && (c == 3 || c == last);
      // Changing inputs mid-transfer must not disturb the latched operation
      op_store  = ~op;
      base_addr = 16'h5555;
      stride    = 16'h0033;
      st_data   = ~sdata;
      mem_ready = stall ? (c % 2 == 0) : 1'b1;
      abort     = (c == abort_cyc);
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
      if (ld_we) n_we++;
    end

    if (abort_cyc < 0) begin
      check_eq($sformatf("%s_done_cyc", tag), done_cyc, exp_done);
      check_eq($sformatf("%s_ld_we", tag), n_we, op ? 0 : 1);
      if (!op) check_eq($sformatf("%s_ld_data", tag), ld_data, exp_ld);
    end else begin
      check_eq($sformatf("%s_no_done", tag), done_cyc, -1);
      check_eq($sformatf("%s_no_ld_we", tag), n_we, 0);
    end
  endtask

  initial begin
    logic [VW-1:0] sdata;

    // Reset values
    @(negedge clk);
    check_eq("reset_out", {busy, done, ld_we, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
    check_eq("reset_ld", ld_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("ld_contig", 1'b0, 16'h0100, 16'h0001, '0, 1'b0, -1, 1'b0);
    run_op("ld_wrap",   1'b0, 16'hFFFE, 16'h0001, '0, 1'b0, -1, 1'b0);
    run_op("ld_abort",  1'b0, 16'h0300, 16'h0001, '0, 1'b0, 6, 1'b0);
    run_op("ld_prio",   1'b0, 16'h0400, 16'h0002, '0, 1'b0, 16, 1'b0);
    run_op("ld_ignore", 1'b0, 16'h0500, 16'h0001, '0, 1'b0, -1, 1'b1);

    // Reset mid-transfer: beats 0..2 complete, reset lands during beat 3
    @(posedge clk); #1;
    cyc       = 0;
    start     = 1'b1;
    op_store  = 1'b0;
    base_addr = 16'h0200;
    stride    = 16'h0001;
    mem_ready = 1'b1;
    abort     = 1'b0;
    for (int j = 0; j < 3; j++) exp_q.push_back('{j + 1, 16'(16'h0200 + j), 1'b0, 16'h0});
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      cyc   = c;
      start = 1'b0;
    end
    @(posedge clk); #1;
    cyc   = 4;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_out", {busy, done, ld_we, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
    check_eq("rst_mid_ld", ld_data, '0);
    exp_ld = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < int'(LANES); i++) sdata[i*DATA_W +: DATA_W] = 16'(16'hA000 + i);
    run_op("st_stall", 1'b1, 16'h0000, 16'h0004, sdata, 1'b1, -1, 1'b0);

    // Trailing idle cycles: nothing further may be issued
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      cyc       = 100 + c;
      start     = 1'b0;
      abort     = 1'b0;
      mem_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("final_idle", {busy, done, ld_we, mem_rd, mem_wr}, 5'b0);
    check_eq("final_ld", ld_data, exp_ld);
    check_eq("queue_empty", exp_q.size(), 0);
    for (int i = 0; i < int'(LANES); i++) begin
      check_eq($sformatf("mem_%0d", i * 4), mem[i*4], 16'(16'hA000 + i));
    end
    check_eq("mem_gap", mem_rdata_at(16'h0001), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [DATA_W-1:0] mem_rdata_at(input logic [ADDR_W-1:0] a);
    return written[a] ? mem[a] : a;
  endfunction

endmodule
